// File: rtl/event_gate_pkg.sv
// rtl/event_gate_pkg.sv - shared states, SURF sizing constants and config check for the chunk gate
package event_gate_pkg;

   localparam int SURF_CHUNK_WORDS = 384;
   localparam int EXPAND_GROUP     = 3;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_SPACE = 2'd1,
      XFER       = 2'd2
   } gate_state_e;

   function automatic bit chunk_fits_groups(input int chunk_words, input int group_words);
      return (group_words > 0) && ((chunk_words % group_words) == 0);
   endfunction

endpackage

// File: rtl/event_gate_stage_fifo.sv
// rtl/event_gate_stage_fifo.sv - shift-register staging FIFO with occupancy count
module event_gate_stage_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 65,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic [CNT_W-1:0] count_o,
   output logic             ready_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok, pop_ok;
   logic [IDX_W-1:0] wr_idx;

   assign ready_o = (count_q < CNT_W'(DEPTH));
   assign push_ok = push_i && ready_o;
   assign pop_ok  = pop_i && (count_q != '0);
   assign head_o  = mem_q[0];
   assign count_o = count_q;

   // On a simultaneous pop the write slot moves down with the shift.
   assign wr_idx = IDX_W'(pop_ok ? (count_q - CNT_W'(1)) : count_q);

   always_comb begin
      mem_d   = mem_q;
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
      if (pop_ok) begin
         for (int i = 0; i < DEPTH - 1; i++) begin
            mem_d[i] = mem_q[i+1];
         end
         mem_d[DEPTH-1] = '0;
      end
      if (push_ok) begin
         mem_d[wr_idx] = push_data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= '0;
         mem_q   <= '{default: '0};
      end else begin
         count_q <= count_d;
         mem_q   <= mem_d;
      end
   end

endmodule

// File: rtl/event_chunk_gate.sv
// rtl/event_chunk_gate.sv - releases SURF event words chunk by chunk in contiguous groups
module event_chunk_gate
   import event_gate_pkg::*;
#(
   parameter int CHUNK_WORDS      = SURF_CHUNK_WORDS,
   parameter int CHUNKS_PER_EVENT = 4,
   parameter int GROUP_WORDS      = EXPAND_GROUP,
   parameter int BUF_DEPTH        = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [63:0] s_axis_tdata,
   input  logic        s_axis_tvalid,
   input  logic        s_axis_tlast,
   output logic        s_axis_tready,
   input  logic        space_avail_i,
   output logic [63:0] payload_o,
   output logic        payload_valid_o,
   output logic        payload_last_o,
   output logic        chunk_done_o,
   output logic        event_done_o,
   output logic        busy_o,
   output logic        err_len_o
);

   localparam int CW_W  = $clog2(CHUNK_WORDS);
   localparam int CK_W  = (CHUNKS_PER_EVENT > 1) ? $clog2(CHUNKS_PER_EVENT) : 1;
   localparam int GC_W  = $clog2(GROUP_WORDS + 1);
   localparam int CNT_W = $clog2(BUF_DEPTH + 1);

   if (!chunk_fits_groups(CHUNK_WORDS, GROUP_WORDS) || (BUF_DEPTH < GROUP_WORDS + 1)) begin : g_bad_cfg
      $error("event_chunk_gate: CHUNK_WORDS must be a multiple of GROUP_WORDS and BUF_DEPTH >= GROUP_WORDS+1");
   end

   gate_state_e      state_q, state_d;
   logic [CW_W-1:0]  cw_q, cw_d;
   logic [CK_W-1:0]  ck_q, ck_d;
   logic [GC_W-1:0]  grp_left_q, grp_left_d;
   logic [64:0]      head;
   logic [CNT_W-1:0] count;
   logic             fifo_ready, pop, chunk_end, event_end;
   logic [63:0]      payload_q;
   logic             valid_q, last_q, chunk_q, err_q;

   event_gate_stage_fifo #(.DEPTH(BUF_DEPTH), .WIDTH(65)) u_stage (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (s_axis_tvalid && s_axis_tready),
      .push_data_i ({s_axis_tlast, s_axis_tdata}),
      .pop_i       (pop),
      .head_o      (head),
      .count_o     (count),
      .ready_o     (fifo_ready)
   );

   assign s_axis_tready = rst_n && fifo_ready;

   // A group only opens with all of its words already staged, so it never stalls midway.
   assign pop       = (state_q == XFER) && ((grp_left_q != '0) || (count >= CNT_W'(GROUP_WORDS)));
   assign chunk_end = (cw_q == CW_W'(CHUNK_WORDS - 1));
   assign event_end = chunk_end && (ck_q == CK_W'(CHUNKS_PER_EVENT - 1));

   always_comb begin
      state_d    = state_q;
      cw_d       = cw_q;
      ck_d       = ck_q;
      grp_left_d = grp_left_q;
      case (state_q)
         IDLE: state_d = WAIT_SPACE;
         WAIT_SPACE: begin
            if (space_avail_i) begin
               state_d = XFER;
               cw_d    = '0;
            end
         end
         XFER: begin
            if (pop) begin
               grp_left_d = (grp_left_q != '0) ? (grp_left_q - GC_W'(1)) : GC_W'(GROUP_WORDS - 1);
               if (chunk_end) begin
                  cw_d    = '0;
                  state_d = WAIT_SPACE;
                  ck_d    = ((CHUNKS_PER_EVENT == 1) || (ck_q == CK_W'(CHUNKS_PER_EVENT - 1)))
                            ? '0 : (ck_q + CK_W'(1));
               end else begin
                  cw_d = cw_q + CW_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cw_q       <= '0;
         ck_q       <= '0;
         grp_left_q <= '0;
         payload_q  <= '0;
         valid_q    <= 1'b0;
         last_q     <= 1'b0;
         chunk_q    <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cw_q       <= cw_d;
         ck_q       <= ck_d;
         grp_left_q <= grp_left_d;
         valid_q    <= pop;
         last_q     <= pop && event_end;
         chunk_q    <= pop && chunk_end;
         if (pop) begin
            payload_q <= head[63:0];
         end
         // Source framing is only checked; the counters always define the event boundary.
         if (pop && (head[64] != event_end)) begin
            err_q <= 1'b1;
         end
      end
   end

   assign payload_o       = payload_q;
   assign payload_valid_o = valid_q;
   assign payload_last_o  = last_q;
   assign event_done_o    = last_q;
   assign chunk_done_o    = chunk_q;
   assign busy_o          = (state_q != IDLE);
   assign err_len_o       = err_q;

endmodule

// File: tb/tb_event_chunk_gate.sv
// tb/tb_event_chunk_gate.sv - scoreboard bench for event_chunk_gate (default and single-word configs)
module tb_event_chunk_gate;

   localparam int CW   = 384;
   localparam int CPE  = 4;
   localparam int EVW  = CW * CPE;
   localparam int CW2  = 384;

   typedef struct {
      logic [63:0] data;
      logic        tlast;
      logic        last;
      logic        chunk;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n = 1'b0, s_tvalid = 1'b0, s_tlast = 1'b0, space = 1'b1;
   logic [63:0] s_tdata = '0;
   logic        s_tready, pv, pl, cd, ed, busy, err;
   logic [63:0] pay;

   logic        rst2_n = 1'b0, s2_tvalid = 1'b0, s2_tlast = 1'b0, space2 = 1'b1;
   logic [63:0] s2_tdata = '0;
   logic        s2_tready, pv2, pl2, cd2, ed2, busy2, err2;
   logic [63:0] pay2;

   event_chunk_gate u_dut (
      .clk(clk), .rst_n(rst_n), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
      .s_axis_tlast(s_tlast), .s_axis_tready(s_tready), .space_avail_i(space),
      .payload_o(pay), .payload_valid_o(pv), .payload_last_o(pl), .chunk_done_o(cd),
      .event_done_o(ed), .busy_o(busy), .err_len_o(err)
   );

   event_chunk_gate #(.CHUNK_WORDS(CW2), .CHUNKS_PER_EVENT(1), .GROUP_WORDS(1), .BUF_DEPTH(4)) u_dut2 (
      .clk(clk), .rst_n(rst2_n), .s_axis_tdata(s2_tdata), .s_axis_tvalid(s2_tvalid),
      .s_axis_tlast(s2_tlast), .s_axis_tready(s2_tready), .space_avail_i(space2),
      .payload_o(pay2), .payload_valid_o(pv2), .payload_last_o(pl2), .chunk_done_o(cd2),
      .event_done_o(ed2), .busy_o(busy2), .err_len_o(err2)
   );

   exp_t q1[$];
   exp_t q2[$];
   int   errors = 0, checks = 0;
   int   mcnt1 = 0, run1 = 0;
   bit   exp_err1 = 1'b0, exp_err2 = 1'b0, done2 = 1'b0;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (pv) begin
            if (q1.size() == 0) begin
               chk("dut1_unexpected_word", 64'd1, 64'd0);
            end else begin
               e = q1.pop_front();
               exp_err1 = exp_err1 | (e.tlast != e.last);
               chk("dut1_data", pay, e.data);
               chk("dut1_last", pl, e.last);
               chk("dut1_chunk_done", cd, e.chunk);
               chk("dut1_event_done", ed, e.last);
               chk("dut1_err_len", err, exp_err1);
            end
            run1++;
            mcnt1++;
         end else begin
            if (run1 != 0) chk("dut1_group_run_mod3", run1 % 3, 0);
            run1 = 0;
            chk("dut1_idle_flags", {pl, cd, ed}, 0);
         end
      end else begin
         run1 = 0;
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst2_n && pv2) begin
         if (q2.size() == 0) begin
            chk("dut2_unexpected_word", 64'd1, 64'd0);
         end else begin
            e = q2.pop_front();
            exp_err2 = exp_err2 | (e.tlast != e.last);
            chk("dut2_data", pay2, e.data);
            chk("dut2_last", pl2, e.last);
            chk("dut2_chunk_done", cd2, e.chunk);
            chk("dut2_event_done", ed2, e.last);
            chk("dut2_err_len", err2, exp_err2);
         end
      end
   end

   task automatic do_reset();
      @(negedge clk); #1;
      rst_n = 1'b0;
      s_tvalid = 1'b0;
      q1.delete();
      exp_err1 = 1'b0;
      mcnt1 = 0;
      @(negedge clk);
      chk("rst_payload", pay, 64'd0);
      chk("rst_flags", {pv, pl, cd, ed, busy, err}, 0);
      chk("rst_tready", s_tready, 0);
      #1 rst_n = 1'b1;
   endtask

   // mode: 0 framed correctly, 1 extra tlast at word 1000, 2 tlast missing at final word
   // vmode: 0 continuous, 1 toggling, 2 random
   task automatic send_event(input int mode, input int vmode, input int abort_at);
      int          k = 0, cyc = 0, base = mcnt1;
      bit          held = 1'b0, v;
      logic [63:0] d = '0;
      logic        tl = 1'b0;
      exp_t        e;
      while (k < EVW) begin
         @(negedge clk); #1;
         if (abort_at > 0 && (mcnt1 - base) >= abort_at) begin
            s_tvalid = 1'b0;
            return;
         end
         if (!held) begin
            v  = (vmode == 0) ? 1'b1 : (vmode == 1) ? ((cyc % 2) == 0) : ($urandom_range(0, 3) != 0);
            d  = {$urandom, $urandom};
            tl = (mode == 1 && k == 1000) || (mode != 2 && k == EVW - 1);
         end else begin
            v = 1'b1;
         end
         cyc++;
         s_tvalid = v; s_tdata = d; s_tlast = tl;
         if (v && s_tready) begin
            e.data = d; e.tlast = tl; e.last = (k == EVW - 1); e.chunk = ((k % CW) == CW - 1);
            q1.push_back(e);
            k++;
            held = 1'b0;
         end else begin
            held = v;
         end
      end
      @(negedge clk); #1;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic wait_mcnt(input int target, input int bound, input string name);
      int n = 0;
      while (mcnt1 < target && n < bound) begin
         @(negedge clk);
         n++;
      end
      chk(name, (mcnt1 >= target), 1);
   endtask

   task automatic drain1(input string name);
      int n = 0;
      while (q1.size() != 0 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      chk(name, q1.size(), 0);
   endtask

   initial begin
      int n;
      do_reset();

      fork
         send_event(0, 0, 0);
         begin
            wait_mcnt(380, 4000, "a_reach_380");
            #1 space = 1'b0;
            wait_mcnt(384, 100, "a_reach_384");
            repeat (50) begin
               @(negedge clk);
               chk("stall_no_valid", pv, 0);
               chk("stall_busy", busy, 1);
            end
            chk("stall_tready_low", s_tready, 0);
            chk("stall_buffered", q1.size(), 4);
            #1 space = 1'b1;
            n = 0;
            while (!pv && n < 6) begin
               @(negedge clk);
               n++;
            end
            chk("resume_latency_1_to_2", (n >= 1 && n <= 2), 1);
         end
      join
      drain1("a_drain");
      chk("a_err_clear", err, 0);

      send_event(0, 1, 0);
      drain1("b_drain");
      chk("b_err_clear", err, 0);

      send_event(1, 2, 0);
      drain1("c_drain");
      chk("c_err_early_tlast", err, 1);

      do_reset();
      send_event(2, 2, 0);
      drain1("d_drain");
      chk("d_err_missing_tlast", err, 1);

      do_reset();
      send_event(0, 0, 200);
      do_reset();
      send_event(0, 2, 0);
      drain1("e_drain");
      chk("e_err_clear", err, 0);

      n = 0;
      while (!done2 && n < 20000) begin
         @(negedge clk);
         n++;
      end
      chk("dut2_finished", done2, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      bit          held = 1'b0, v;
      logic [63:0] d = '0;
      logic        tl = 1'b0;
      exp_t        e;
      int          n;
      repeat (2) @(negedge clk);
      chk("dut2_rst_flags", {pv2, pl2, cd2, ed2, busy2, err2, s2_tready}, 0);
      #1 rst2_n = 1'b1;
      for (int ev = 0; ev < 3; ev++) begin
         int k = 0;
         while (k < CW2) begin
            @(negedge clk); #1;
            space2 = ($urandom_range(0, 1) != 0);
            if (!held) begin
               v  = ($urandom_range(0, 2) != 0);
               d  = {$urandom, $urandom};
               tl = (k == CW2 - 1);
            end else begin
               v = 1'b1;
            end
            s2_tvalid = v; s2_tdata = d; s2_tlast = tl;
            if (v && s2_tready) begin
               e.data = d; e.tlast = tl; e.last = (k == CW2 - 1); e.chunk = (k == CW2 - 1);
               q2.push_back(e);
               k++;
               held = 1'b0;
            end else begin
               held = v;
            end
         end
      end
      @(negedge clk); #1;
      s2_tvalid = 1'b0;
      space2 = 1'b1;
      n = 0;
      while (q2.size() != 0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("dut2_drain", q2.size(), 0);
      chk("dut2_err_clear", err2, 0);
      done2 = 1'b1;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation exceeded time limit, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

endmodule
